// File: rtl/ps2_pkg.sv
// Shared constants, frame FSM encoding and key-word helper for the PS/2 keyboard receiver.
package ps2_pkg;
  localparam logic [7:0] PS2_EXT_CODE = 8'hE0;
  localparam logic [7:0] PS2_BRK_CODE = 8'hF0;
  localparam int         KEY_W        = 16;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  function automatic logic [KEY_W-1:0] key_word(input logic ext, input logic [7:0] b);
    return {7'b0, ext, b};
  endfunction
endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchroniser plus FILTER_LEN-sample glitch filter for one PS/2 line; fall pulses on a filtered 1->0.
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic fall
);
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      fall <= 1'b0;
      // cnt counts consecutive samples disagreeing with the filtered level
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= sync[1];
        cnt   <= '0;
        fall  <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host frame receiver with E0/F0 prefix decoding into a held-key word.
// Optional partial-frame timeout enabled by defining PS2_TIMEOUT_EN.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic [KEY_W-1:0] key,
  output logic [7:0]       code,
  output logic             code_strobe,
  output logic             frame_err
);
  logic   fall, sdata, unused_data_fall;
  state_t state, state_n;
  logic [2:0] bitcnt, bitcnt_n;
  logic [7:0] sreg, sreg_n;
  logic par, par_n;
  logic ext, brk;
  logic frame_done, frame_good, frame_bad, to_hit;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(clk), .rst(rst), .din(ps2_clk), .level(), .fall(fall)
  );
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk(clk), .rst(rst), .din(ps2_data), .level(sdata), .fall(unused_data_fall)
  );

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            to_cnt <= '0;
    else if (fall || state == IDLE)     to_cnt <= '0;
    else if (to_cnt != TW'(TIMEOUT_CYCLES)) to_cnt <= to_cnt + 1'b1;
  end

  assign to_hit = (state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES));
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      bitcnt <= '0;
      sreg   <= '0;
      par    <= 1'b0;
    end else begin
      state  <= state_n;
      bitcnt <= bitcnt_n;
      sreg   <= sreg_n;
      par    <= par_n;
    end
  end

  always_comb begin
    state_n    = state;
    bitcnt_n   = bitcnt;
    sreg_n     = sreg;
    par_n      = par;
    frame_done = 1'b0;
    if (to_hit) begin
      state_n = IDLE;
    end else if (fall) begin
      case (state)
        IDLE: if (!sdata) begin
          state_n  = DATA;
          bitcnt_n = '0;
        end
        DATA: begin
          sreg_n   = {sdata, sreg[7:1]};
          bitcnt_n = bitcnt + 3'd1;
          if (bitcnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          par_n   = sdata;
          state_n = STOP;
        end
        STOP: begin
          frame_done = 1'b1;
          state_n    = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Odd parity over data plus parity bit, and stop bit must be high.
  assign frame_good = frame_done && sdata && (^{sreg, par});
  assign frame_bad  = (frame_done && !frame_good) || to_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key         <= '0;
      code        <= '0;
      code_strobe <= 1'b0;
      frame_err   <= 1'b0;
      ext         <= 1'b0;
      brk         <= 1'b0;
    end else begin
      code_strobe <= frame_good;
      frame_err   <= frame_bad;
      if (frame_good) begin
        code <= sreg;
        if (sreg == PS2_EXT_CODE) begin
          ext <= 1'b1;
        end else if (sreg == PS2_BRK_CODE) begin
          brk <= 1'b1;
        end else begin
          // Release only clears the word if it names the key currently held.
          if (!brk)                          key <= key_word(ext, sreg);
          else if (key == key_word(ext, sreg)) key <= '0;
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end else if (frame_bad) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: directed plan plus random byte stream against a scancode model.
module tb_ps2_keyboard_rx;
  localparam int TO_CYC = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] key;
  logic [7:0]  code;
  logic        code_strobe, frame_err;

  int errors = 0;
  int checks = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;

  logic [15:0] m_key;
  logic [7:0]  m_code;
  bit          m_ext, m_brk;

  ps2_keyboard_rx #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key(key), .code(code), .code_strobe(code_strobe), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // A strobe stuck high for several cycles inflates these counts.
  always @(negedge clk) begin
    if (code_strobe) strobe_cnt <= strobe_cnt + 1;
    if (frame_err)   err_cnt    <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    p = ~(^b) ^ bad_par;
    return {~bad_stop, p, b, 1'b0};
  endfunction

  // Each bit: data settles, clock low 20 cycles, high 20 cycles; optional 2-cycle low glitch in the high phase.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_at);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (10) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (20) @(posedge clk);
      ps2_clk = 1'b1;
      if (i == glitch_at) begin
        repeat (8) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(posedge clk);
      end else begin
        repeat (20) @(posedge clk);
      end
    end
    ps2_data = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
  endtask

  function automatic void model_byte(input logic [7:0] b);
    m_code = b;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (!m_brk) m_key = {7'b0, m_ext, b};
      else if (m_key == {7'b0, m_ext, b}) m_key = 16'h0000;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  task automatic frame(input string tag, input logic [7:0] b, input bit bad_par, input bit bad_stop,
                       input int glitch_at);
    int s0, e0;
    bit good;
    s0 = strobe_cnt;
    e0 = err_cnt;
    good = !bad_par && !bad_stop;
    send_bits(mk_frame(b, bad_par, bad_stop), 11, glitch_at);
    if (good) model_byte(b);
    else begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    check({tag, ".strobes"}, 16'(strobe_cnt - s0), good ? 16'd1 : 16'd0);
    check({tag, ".errs"},    16'(err_cnt - e0),    good ? 16'd0 : 16'd1);
    check({tag, ".code"},    {8'h0, code},         {8'h0, m_code});
    check({tag, ".key"},     key,                  m_key);
  endtask

  initial begin
    int s0, e0, r;
    logic [7:0] b;
    m_key = '0; m_code = '0; m_ext = 0; m_brk = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.key", key, 16'h0);
    check("rst.code", {8'h0, code}, 16'h0);
    check("rst.flags", {14'h0, code_strobe, frame_err}, 16'h0);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    frame("make1c", 8'h1C, 0, 0, -1);
    check("make1c.literal", key, 16'h001C);
    frame("brkF0", 8'hF0, 0, 0, -1);
    frame("brk1c", 8'h1C, 0, 0, -1);
    check("brk1c.literal", key, 16'h0000);
    frame("make1c_b", 8'h1C, 0, 0, -1);
    frame("brkF0_b", 8'hF0, 0, 0, -1);
    frame("rel1b", 8'h1B, 0, 0, -1);
    check("rel1b.literal", key, 16'h001C);
    frame("extE0", 8'hE0, 0, 0, -1);
    frame("ext75", 8'h75, 0, 0, -1);
    check("ext75.literal", key, 16'h0175);
    frame("xE0", 8'hE0, 0, 0, -1);
    frame("xF0", 8'hF0, 0, 0, -1);
    frame("x75", 8'h75, 0, 0, -1);
    check("x75.literal", key, 16'h0000);
    frame("make1c_c", 8'h1C, 0, 0, -1);
    frame("badpar", 8'h1C, 1, 0, -1);
    frame("badstop", 8'h23, 0, 1, -1);
    check("bad.literal", key, 16'h001C);
    frame("glitch", 8'h1C, 0, 0, 4);
    check("glitch.literal", {8'h0, code}, 16'h001C);

`ifdef PS2_TIMEOUT_EN
    frame("preE0", 8'hE0, 0, 0, -1);
    s0 = strobe_cnt;
    e0 = err_cnt;
    send_bits(mk_frame(8'h5A, 0, 0), 5, -1);
    repeat (TO_CYC + 100) @(posedge clk);
    @(negedge clk);
    m_ext = 1'b0;
    check("timeout.errs", 16'(err_cnt - e0), 16'd1);
    check("timeout.strobes", 16'(strobe_cnt - s0), 16'd0);
    check("timeout.key", key, m_key);
    frame("after_to", 8'h1C, 0, 0, -1);
`endif

    send_bits(mk_frame(8'h5A, 0, 0), 5, -1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midrst.key", key, 16'h0);
    check("midrst.code", {8'h0, code}, 16'h0);
    check("midrst.flags", {14'h0, code_strobe, frame_err}, 16'h0);
    rst = 1'b0;
    m_key = '0; m_code = '0; m_ext = 0; m_brk = 0;
    repeat (5) @(posedge clk);
    frame("after_rst", 8'h1C, 0, 0, -1);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 2)       b = 8'hE0;
      else if (r < 4)  b = 8'hF0;
      else if (r < 6)  b = m_key[7:0];
      else             b = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 9);
      frame($sformatf("rnd%0d", n), b, r == 0, r == 1, (r == 2) ? int'($urandom_range(0, 9)) : -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
